// File: rtl/sprite_compositor.sv
// sprite_compositor
//   Multi-sprite pixel compositor on the VGA display path. Each sprite channel
//   holds a double-buffered position (shadow written any time, committed at
//   frame end), tests the current pixel against its box and walks a row-major
//   ROM address counter. A two-stage pixel pipeline then merges the sprite ROM
//   bits over the background in fixed priority (lowest index wins) and
//   accumulates per-sprite overlap flags, reported once per frame.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   pix_en            pixel strobe; all pipeline/frame state moves only with it
//   x, y, active      current pixel coordinates and visible-region flag
//   screen_end        frame boundary, sampled with pix_en
//   wr_en, wr_sel,
//   wr_x, wr_y, wr_vis shadow position write port (not gated by pix_en)
//   rom_addr          per-sprite ROM address, sprite i at [i*ADDR_W +: ADDR_W]
//   rom_data, bg_data ROM bits for the previous pixel, returned before next pix_en
//   sprite_color      per-sprite opaque color, sprite i at [i*COLOR_W +: COLOR_W]
//   fg_color,bg_color colors for background bit 1 / 0
//   color_out         composited pixel, two pixel enables after its x/y
//   collision         per-sprite collision flags of the previous frame

// One sprite channel: position registers, box hit test and address counter.
module sprite_channel #(
  parameter int SPRITE_W = 60,
  parameter int SPRITE_H = 80,
  parameter int ADDR_W   = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic              screen_end,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic              wr,
  input  logic [9:0]        wr_x,
  input  logic [8:0]        wr_y,
  input  logic              wr_vis,
  output logic              hit,
  output logic [ADDR_W-1:0] addr
);
  localparam int               LAST_I = SPRITE_W * SPRITE_H - 1;
  localparam logic [ADDR_W-1:0] LAST  = LAST_I[ADDR_W-1:0];
  localparam logic [10:0]      SW11   = SPRITE_W[10:0];
  localparam logic [10:0]      SH11   = SPRITE_H[10:0];

  logic [9:0]        sh_x, cm_x;
  logic [8:0]        sh_y, cm_y;
  logic              sh_vis, cm_vis;
  logic [ADDR_W-1:0] cnt;
  logic [10:0]       x_end, y_end;

  // Shadow takes writes on any clk; the committed copy only moves at frame
  // end, so a write landing on the screen_end clk waits one more frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_x   <= '0;
      sh_y   <= '0;
      sh_vis <= 1'b0;
      cm_x   <= '0;
      cm_y   <= '0;
      cm_vis <= 1'b0;
    end else begin
      if (wr) begin
        sh_x   <= wr_x;
        sh_y   <= wr_y;
        sh_vis <= wr_vis;
      end
      if (pix_en && screen_end) begin
        cm_x   <= sh_x;
        cm_y   <= sh_y;
        cm_vis <= sh_vis;
      end
    end
  end

  // 11-bit box ends: a sprite hanging off the right/bottom edge is clipped
  // rather than wrapping back to column/row 0.
  assign x_end = {1'b0, cm_x} + SW11;
  assign y_end = {2'b0, cm_y} + SH11;
  assign hit   = cm_vis && (x >= cm_x) && ({1'b0, x} < x_end) &&
                 (y >= cm_y) && ({2'b0, y} < y_end);

  // addr is the pre-increment count, so the first hit pixel of a frame reads
  // ROM word 0 and the ROM has until the next pix_en to return it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      addr <= '0;
    end else if (pix_en) begin
      addr <= cnt;
      if (screen_end)
        cnt <= '0;
      else if (hit && cnt != LAST)
        cnt <= cnt + 1'b1;
    end
  end
endmodule

module sprite_compositor #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 60,
  parameter int SPRITE_H    = 80,
  parameter int ADDR_W      = 13,
  parameter int COLOR_W     = 12
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pix_en,
  input  logic [9:0]                     x,
  input  logic [8:0]                     y,
  input  logic                           active,
  input  logic                           screen_end,
  input  logic                           wr_en,
  input  logic [2:0]                     wr_sel,
  input  logic [9:0]                     wr_x,
  input  logic [8:0]                     wr_y,
  input  logic                           wr_vis,
  output logic [NUM_SPRITES*ADDR_W-1:0]  rom_addr,
  input  logic [NUM_SPRITES-1:0]         rom_data,
  input  logic                           bg_data,
  input  logic [NUM_SPRITES*COLOR_W-1:0] sprite_color,
  input  logic [COLOR_W-1:0]             fg_color,
  input  logic [COLOR_W-1:0]             bg_color,
  output logic [COLOR_W-1:0]             color_out,
  output logic [NUM_SPRITES-1:0]         collision
);
  logic [NUM_SPRITES-1:0] hit, hit_d, opaque, col_set, frame_col;
  logic                   active_d;
  logic [COLOR_W-1:0]     pick;

  // wr_sel values with no matching channel select nothing and are dropped.
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_ch
    sprite_channel #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .ADDR_W   (ADDR_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .pix_en     (pix_en),
      .screen_end (screen_end),
      .x          (x),
      .y          (y),
      .wr         (wr_en && (wr_sel == 3'(i))),
      .wr_x       (wr_x),
      .wr_y       (wr_y),
      .wr_vis     (wr_vis),
      .hit        (hit[i]),
      .addr       (rom_addr[i*ADDR_W +: ADDR_W])
    );
  end

  // Stage 2: rom_data/bg_data belong to the pixel captured in hit_d.
  assign opaque = hit_d & rom_data;

  // Walk from the highest index down so the lowest opaque sprite wins.
  always_comb begin
    pick = bg_data ? fg_color : bg_color;
    for (int i = NUM_SPRITES - 1; i >= 0; i--)
      if (opaque[i]) pick = sprite_color[i*COLOR_W +: COLOR_W];
  end

  // A sprite collides when it and at least one other sprite are opaque here.
  always_comb begin
    col_set = '0;
    for (int i = 0; i < NUM_SPRITES; i++)
      col_set[i] = opaque[i] && ((opaque & ~(NUM_SPRITES'(1) << i)) != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_d     <= '0;
      active_d  <= 1'b0;
      color_out <= '0;
      frame_col <= '0;
      collision <= '0;
    end else if (pix_en) begin
      hit_d     <= hit;
      active_d  <= active;
      color_out <= active_d ? pick : '0;
      // The boundary pixel's own overlaps still belong to the ending frame.
      if (screen_end) begin
        collision <= frame_col | col_set;
        frame_col <= '0;
      end else begin
        frame_col <= frame_col | col_set;
      end
    end
  end
endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;
  localparam int NS = 4, SW = 60, SH = 80, AW = 13, CW = 12;

  logic clk = 1'b0, reset = 1'b1, pix_en = 1'b0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic active = 1'b0, screen_end = 1'b0;
  logic wr_en = 1'b0;
  logic [2:0] wr_sel = '0;
  logic [9:0] wr_x = '0;
  logic [8:0] wr_y = '0;
  logic wr_vis = 1'b0;
  logic [NS*AW-1:0] rom_addr;
  logic [NS-1:0]    rom_data;
  logic             bg_data = 1'b0;
  logic [NS*CW-1:0] sprite_color;
  logic [CW-1:0]    fg_color = 12'hAAA, bg_color = 12'h555;
  logic [CW-1:0]    color_out;
  logic [NS-1:0]    collision;

  sprite_compositor #(.NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH),
                      .ADDR_W(AW), .COLOR_W(CW)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y), .active(active),
    .screen_end(screen_end), .wr_en(wr_en), .wr_sel(wr_sel), .wr_x(wr_x),
    .wr_y(wr_y), .wr_vis(wr_vis), .rom_addr(rom_addr), .rom_data(rom_data),
    .bg_data(bg_data), .sprite_color(sprite_color), .fg_color(fg_color),
    .bg_color(bg_color), .color_out(color_out), .collision(collision));

  always #5 clk = ~clk;

  // ROM contents: mode 0 pseudo-random pattern, 1 all ones, 2 all zeros
  int rom_mode[NS];
  int seed[NS];
  logic [CW-1:0] scol[NS];

  function automatic logic rom_bit(input int mode, input int sd, input int a);
    logic [31:0] h;
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    h = 32'(a) * 32'h9E3779B1 + 32'(sd);
    return h[19];
  endfunction

  always_comb begin
    rom_data = '0;
    for (int i = 0; i < NS; i++)
      rom_data[i] = rom_bit(rom_mode[i], seed[i], int'(rom_addr[i*AW +: AW]));
  end

  always_comb begin
    sprite_color = '0;
    for (int i = 0; i < NS; i++) sprite_color[i*CW +: CW] = scol[i];
  end

  // Reference model state
  int sh_x[NS], sh_y[NS], cm_x[NS], cm_y[NS], cnt[NS], exp_addr[NS];
  bit sh_v[NS], cm_v[NS];
  logic [NS-1:0] fc, coll_exp, prev_opq;
  bit prev_act, prev_bg;
  logic [CW-1:0] color_exp;
  bit pend_wr, pend_v;
  int pend_sel, pend_x, pend_y;
  bit cnt_en;
  logic [CW-1:0] cnt_col;
  int hits_seen;

  int n_checks = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d t=%0t)", tag, got, exp, x, y, $time);
    end
  endtask

  function automatic logic [31:0] ra(input int i);
    return 32'(rom_addr[i*AW +: AW]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_v[i] = 0;
      cm_x[i] = 0; cm_y[i] = 0; cm_v[i] = 0;
      cnt[i] = 0; exp_addr[i] = 0;
    end
    fc = '0; coll_exp = '0; prev_opq = '0;
    prev_act = 0; prev_bg = 0; color_exp = '0; pend_wr = 0;
  endtask

  task automatic model_write(input int sel, input int px, input int py, input bit v);
    if (sel < NS) begin sh_x[sel] = px; sh_y[sel] = py; sh_v[sel] = v; end
  endtask

  // Shadow write on a clk with pix_en low; screen_end and x/y are wiggled too,
  // which must not move anything but the shadow registers.
  task automatic wr_pos(input int sel, input int px, input int py, input bit v);
    @(negedge clk);
    wr_en = 1; wr_sel = sel[2:0]; wr_x = px[9:0]; wr_y = py[8:0]; wr_vis = v;
    screen_end = 1; x = 10'($urandom); y = 9'($urandom);
    @(negedge clk);
    wr_en = 0; screen_end = 0;
    model_write(sel, px, py, v);
  endtask

  task automatic pixel(input int px, input int py, input bit act, input bit se);
    logic [NS-1:0] opq, sets;
    logic [CW-1:0] c;
    bit h;
    // second stage for the previous pixel
    c = prev_bg ? fg_color : bg_color;
    for (int i = NS - 1; i >= 0; i--) if (prev_opq[i]) c = scol[i];
    color_exp = prev_act ? c : '0;
    sets = ($countones(prev_opq) >= 2) ? prev_opq : '0;
    if (se) begin coll_exp = fc | sets; fc = '0; end
    else fc = fc | sets;
    // this pixel: box test against committed positions, address = hits so far
    opq = '0;
    for (int i = 0; i < NS; i++) begin
      h = cm_v[i] && px >= cm_x[i] && px < cm_x[i] + SW && py >= cm_y[i] && py < cm_y[i] + SH;
      exp_addr[i] = cnt[i];
      opq[i] = h && rom_bit(rom_mode[i], seed[i], cnt[i]);
      if (se) cnt[i] = 0;
      else if (h && cnt[i] < SW * SH - 1) cnt[i]++;
    end
    @(negedge clk);
    x = px[9:0]; y = py[8:0]; active = act; screen_end = se;
    bg_data = prev_bg; pix_en = 1;
    if (pend_wr) begin
      wr_en = 1; wr_sel = pend_sel[2:0]; wr_x = pend_x[9:0]; wr_y = pend_y[8:0]; wr_vis = pend_v;
    end
    if (se) for (int i = 0; i < NS; i++) begin cm_x[i] = sh_x[i]; cm_y[i] = sh_y[i]; cm_v[i] = sh_v[i]; end
    if (pend_wr) begin model_write(pend_sel, pend_x, pend_y, pend_v); pend_wr = 0; end
    prev_opq = opq; prev_act = act; prev_bg = ((px >> 2) ^ (py >> 3)) & 1;
    @(negedge clk);
    pix_en = 0; screen_end = 0; wr_en = 0;
    for (int i = 0; i < NS; i++) chk($sformatf("rom_addr%0d", i), ra(i), 32'(exp_addr[i]));
    chk("color_out", 32'(color_out), 32'(color_exp));
    chk("collision", 32'(collision), 32'(coll_exp));
    if (cnt_en && color_out == cnt_col) hits_seen++;
  endtask

  task automatic scan(input int x0, input int y0, input int w, input int h);
    for (int yy = y0; yy < y0 + h; yy++)
      for (int xx = x0; xx < x0 + w; xx++) pixel(xx, yy, 1, 0);
  endtask

  task automatic end_frame();
    pixel(799, 479, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    scol[0] = 12'hF00; scol[1] = 12'h0F0; scol[2] = 12'h00F; scol[3] = 12'hFF0;
    for (int i = 0; i < NS; i++) begin rom_mode[i] = 0; seed[i] = int'($urandom); end
    cnt_en = 0; cnt_col = '0; hits_seen = 0;
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_color", 32'(color_out), 32'd0);
    chk("rst_collision", 32'(collision), 32'd0);
    reset = 0;
    @(negedge clk);

    // full sprite scan: row-major addressing and saturation
    wr_pos(0, 100, 200, 1);
    end_frame();
    scan(90, 190, 5, 2);
    for (int yy = 200; yy < 280; yy++)
      for (int xx = 100; xx < 160; xx++) begin
        pixel(xx, yy, 1, 0);
        if (xx == 100 && yy == 200) chk("addr_first", ra(0), 32'd0);
        if (xx == 100 && yy == 201) chk("addr_row1", ra(0), 32'd60);
      end
    chk("addr_last", ra(0), 32'd4799);
    pixel(150, 250, 1, 0);
    chk("addr_sat", ra(0), 32'd4799);
    end_frame();

    // mid-frame move takes effect only at the frame boundary
    scan(100, 200, 10, 3);
    wr_pos(0, 300, 100, 1);
    scan(100, 203, 10, 3);
    scan(300, 100, 5, 2);
    end_frame();
    scan(300, 100, 10, 4);
    scan(100, 200, 5, 2);
    end_frame();
    // write in the same clk as screen_end waits for the next boundary
    pend_wr = 1; pend_sel = 0; pend_x = 400; pend_y = 300; pend_v = 1;
    end_frame();
    scan(400, 300, 4, 2);
    scan(300, 100, 4, 2);
    end_frame();
    scan(400, 300, 4, 2);
    end_frame();

    // overlap, both opaque: priority and collision flags
    wr_pos(0, 50, 50, 1);
    wr_pos(1, 60, 55, 1);
    end_frame();
    rom_mode[0] = 1; rom_mode[1] = 1;
    scan(55, 52, 20, 10);
    wr_pos(1, 200, 50, 1);
    end_frame();
    chk("coll_set", 32'(collision), 32'h3);
    scan(55, 52, 20, 10);
    chk("coll_hold", 32'(collision), 32'h3);
    end_frame();
    chk("coll_clear", 32'(collision), 32'h0);

    // overlap with only sprite 1 opaque
    rom_mode[0] = 2;
    wr_pos(1, 60, 55, 1);
    end_frame();
    for (int yy = 52; yy < 62; yy++)
      for (int xx = 55; xx < 75; xx++) begin
        pixel(xx, yy, 1, 0);
        if (xx == 67 && yy == 60) chk("color_s1", 32'(color_out), 32'(scol[1]));
      end
    end_frame();
    chk("coll_none", 32'(collision), 32'h0);

    // clipping at the bottom-right corner
    wr_pos(0, 0, 0, 0);
    wr_pos(1, 0, 0, 0);
    wr_pos(2, 620, 460, 1);
    end_frame();
    rom_mode[2] = 1;
    cnt_en = 1; cnt_col = scol[2]; hits_seen = 0;
    scan(600, 450, 40, 30);
    pixel(700, 470, 0, 0);
    cnt_en = 0;
    scan(0, 455, 12, 20);
    end_frame();
    chk("clip_pixels", 32'(hits_seen), 32'd400);
    pixel(620, 460, 1, 0);
    chk("addr_restart", ra(2), 32'd0);
    pixel(621, 460, 1, 0);
    end_frame();

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      int bx, by;
      for (int i = 0; i < NS; i++) begin
        rom_mode[i] = ($urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0;
        seed[i] = int'($urandom);
      end
      repeat (4) wr_pos(int'($urandom_range(7)), 200 + int'($urandom_range(59)),
                        100 + int'($urandom_range(49)), $urandom_range(3) != 0);
      end_frame();
      bx = 200 + int'($urandom_range(59));
      by = 100 + int'($urandom_range(59));
      for (int yy = by; yy < by + 25; yy++) begin
        if (yy == by + 12)
          wr_pos(int'($urandom_range(7)), 200 + int'($urandom_range(59)),
                 100 + int'($urandom_range(49)), 1);
        for (int xx = bx; xx < bx + 50; xx++) pixel(xx, yy, $urandom_range(7) != 0, 0);
      end
      if ($urandom_range(1) == 1) begin
        pend_wr = 1; pend_sel = int'($urandom_range(7));
        pend_x = 200 + int'($urandom_range(59)); pend_y = 100 + int'($urandom_range(49));
        pend_v = 1;
      end
      end_frame();
    end

    // asynchronous reset mid-frame
    for (int i = 0; i < NS; i++) rom_mode[i] = 1;
    wr_pos(0, 200, 100, 1);
    end_frame();
    scan(200, 100, 5, 2);
    #3 reset = 1;
    #1;
    chk("mid_rst_color", 32'(color_out), 32'd0);
    chk("mid_rst_collision", 32'(collision), 32'd0);
    chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    scan(200, 100, 5, 2);
    end_frame();
    scan(200, 100, 3, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
